// File: rtl/adrv9001_mssi_sync_seq.sv
// MSSI synchronisation sequencer: quiesces the channel enables, pulses mssi_sync,
// waits a settle interval and then hands the enables back to the control layer.
module adrv9001_mssi_sync_seq #(
  parameter int CNT_WIDTH = 16,
  parameter int CH_NUM    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sync_req,
  input  logic                 ext_sync,
  input  logic                 ext_sync_en,
  input  logic [CNT_WIDTH-1:0] cfg_pre_len,
  input  logic [CNT_WIDTH-1:0] cfg_pulse_len,
  input  logic [CNT_WIDTH-1:0] cfg_settle_len,
  input  logic [CH_NUM-1:0]    ch_enable_req,
  input  logic                 err_clr,
  output logic [CH_NUM-1:0]    ch_enable,
  output logic                 mssi_sync,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           sync_count,
  output logic                 err_overrun
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_QUIESCE = 2'd1;
  localparam logic [1:0] S_PULSE   = 2'd2;
  localparam logic [1:0] S_SETTLE  = 2'd3;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] pulse_m1_q, pulse_m1_d;
  logic [CNT_WIDTH-1:0] settle_m1_q, settle_m1_d;
  logic [CH_NUM-1:0]    ch_enable_q, ch_enable_d;
  logic                 mssi_q, mssi_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [7:0]           count_q, count_d;
  logic                 err_q, err_d;
  logic                 trig_prev_q;
  logic                 trig;
  logic                 overrun;
  logic                 idle_next;

  // Lengths are clamped to 1, so the stored value is max(len,1)-1.
  function automatic logic [CNT_WIDTH-1:0] len_m1(input logic [CNT_WIDTH-1:0] len);
    return (len == '0) ? '0 : len - CNT_ONE;
  endfunction

  assign trig = sync_req | (ext_sync & ext_sync_en);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pulse_m1_d  = pulse_m1_q;
    settle_m1_d = settle_m1_q;
    done_d      = 1'b0;
    count_d     = count_q;
    case (state_q)
      S_IDLE: begin
        if (trig) begin
          state_d     = S_QUIESCE;
          cnt_d       = len_m1(cfg_pre_len);
          pulse_m1_d  = len_m1(cfg_pulse_len);
          settle_m1_d = len_m1(cfg_settle_len);
        end
      end
      S_QUIESCE: begin
        if (cnt_q == '0) begin
          state_d = S_PULSE;
          cnt_d   = pulse_m1_q;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          state_d = S_SETTLE;
          cnt_d   = settle_m1_q;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          count_d = count_q + 8'd1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Only a fresh trigger edge while running is an overrun; a held request is not.
  assign overrun   = (state_q != S_IDLE) & trig & ~trig_prev_q;
  assign err_d     = overrun ? 1'b1 : (err_clr ? 1'b0 : err_q);
  assign idle_next = (state_d == S_IDLE);
  assign mssi_d    = (state_d == S_PULSE);
  assign busy_d    = ~idle_next;

  generate
    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch_gate
      assign ch_enable_d[gi] = ch_enable_req[gi] & idle_next;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pulse_m1_q  <= '0;
      settle_m1_q <= '0;
      ch_enable_q <= '0;
      mssi_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= 8'd0;
      err_q       <= 1'b0;
      trig_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pulse_m1_q  <= pulse_m1_d;
      settle_m1_q <= settle_m1_d;
      ch_enable_q <= ch_enable_d;
      mssi_q      <= mssi_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      count_q     <= count_d;
      err_q       <= err_d;
      trig_prev_q <= trig;
    end
  end

  assign ch_enable   = ch_enable_q;
  assign mssi_sync   = mssi_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign sync_count  = count_q;
  assign err_overrun = err_q;

endmodule

// File: tb/tb_adrv9001_mssi_sync_seq.sv
// Directed bench for adrv9001_mssi_sync_seq; checks every cycle of each sequence.
module tb_adrv9001_mssi_sync_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        sync_req, ext_sync, ext_sync_en, err_clr;
  logic [15:0] cfg_pre_len, cfg_pulse_len, cfg_settle_len;
  logic [3:0]  ch_enable_req;
  logic [3:0]  ch_enable;
  logic        mssi_sync, busy, done, err_overrun;
  logic [7:0]  sync_count;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_cnt = 8'd0;
  logic        exp_err = 1'b0;

  adrv9001_mssi_sync_seq dut (
    .clk(clk), .rst(rst), .sync_req(sync_req), .ext_sync(ext_sync),
    .ext_sync_en(ext_sync_en), .cfg_pre_len(cfg_pre_len), .cfg_pulse_len(cfg_pulse_len),
    .cfg_settle_len(cfg_settle_len), .ch_enable_req(ch_enable_req), .err_clr(err_clr),
    .ch_enable(ch_enable), .mssi_sync(mssi_sync), .busy(busy), .done(done),
    .sync_count(sync_count), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One full sequence; mode 0=sync_req, 1=ext_sync, 2=both. inj_k/clr_k pulse
  // sync_req/err_clr after observing cycle k; chg alters cfg and requests mid-run.
  task automatic run_seq(input string tag, input int pre, input int pulse, input int settle,
                         input int mode, input int inj_k, input int clr_k, input bit chg);
    int p, w, s, t;
    p = (pre == 0) ? 1 : pre;
    w = (pulse == 0) ? 1 : pulse;
    s = (settle == 0) ? 1 : settle;
    t = p + w + s;
    cfg_pre_len    = pre[15:0];
    cfg_pulse_len  = pulse[15:0];
    cfg_settle_len = settle[15:0];
    ext_sync_en    = (mode != 0);
    sync_req       = (mode != 1);
    ext_sync       = (mode != 0);
    tick;
    sync_req = 1'b0;
    ext_sync = 1'b0;
    for (int k = 0; k <= t; k++) begin
      chk({tag, "_mssi"}, {31'd0, mssi_sync}, {31'd0, (k >= p && k < p + w)});
      chk({tag, "_busy"}, {31'd0, busy}, {31'd0, (k < t)});
      chk({tag, "_done"}, {31'd0, done}, {31'd0, (k == t)});
      chk({tag, "_ch"}, {28'd0, ch_enable}, {28'd0, ((k == t) ? ch_enable_req : 4'b0000)});
      chk({tag, "_err"}, {31'd0, err_overrun}, {31'd0, exp_err});
      if (k == t) begin
        exp_cnt = exp_cnt + 8'd1;
        chk({tag, "_count"}, {24'd0, sync_count}, {24'd0, exp_cnt});
      end else begin
        sync_req = (k == inj_k);
        err_clr  = (k == clr_k);
        if (k == inj_k) exp_err = 1'b1;
        else if (k == clr_k) exp_err = 1'b0;
        if (chg && k == 0) begin
          cfg_pre_len    = 16'd9;
          cfg_pulse_len  = 16'd9;
          cfg_settle_len = 16'd9;
          ch_enable_req  = ~ch_enable_req;
        end
        tick;
      end
    end
    sync_req    = 1'b0;
    err_clr     = 1'b0;
    ext_sync_en = 1'b0;
    $display("seq %s pre=%0d pulse=%0d settle=%0d count=%0d", tag, pre, pulse, settle, sync_count);
  endtask

  initial begin
    rst = 1'b1; sync_req = 1'b0; ext_sync = 1'b0; ext_sync_en = 1'b0; err_clr = 1'b0;
    cfg_pre_len = '0; cfg_pulse_len = '0; cfg_settle_len = '0; ch_enable_req = 4'b1111;
    tick; tick;
    chk("rst_ch", {28'd0, ch_enable}, 32'd0);
    chk("rst_mssi", {31'd0, mssi_sync}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_count", {24'd0, sync_count}, 32'd0);
    chk("rst_err", {31'd0, err_overrun}, 32'd0);

    rst = 1'b0;
    tick;
    chk("idle_ch_1111", {28'd0, ch_enable}, 32'hF);
    ch_enable_req = 4'b0101;
    tick;
    chk("idle_ch_0101", {28'd0, ch_enable}, 32'h5);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    ch_enable_req = 4'b1111;
    tick;

    run_seq("basic", 2, 3, 4, 0, -1, -1, 1'b0);
    run_seq("zero", 0, 0, 0, 0, -1, -1, 1'b0);

    // External trigger ignored while gated off
    ext_sync_en = 1'b0; ext_sync = 1'b1;
    tick;
    ext_sync = 1'b0;
    tick;
    chk("extoff_busy", {31'd0, busy}, 32'd0);
    chk("extoff_count", {24'd0, sync_count}, {24'd0, exp_cnt});

    run_seq("ext", 1, 1, 1, 1, -1, -1, 1'b0);
    run_seq("both", 1, 2, 1, 2, -1, -1, 1'b0);
    tick;
    chk("both_single_busy", {31'd0, busy}, 32'd0);
    chk("both_single_count", {24'd0, sync_count}, {24'd0, exp_cnt});

    // Overrun in PULSE, stays sticky, clears, then clear coincident with new overrun
    run_seq("ovr", 2, 10, 2, 0, 5, -1, 1'b0);
    tick; tick; tick;
    chk("ovr_sticky", {31'd0, err_overrun}, 32'd1);
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    exp_err = 1'b0;
    chk("ovr_cleared", {31'd0, err_overrun}, 32'd0);
    run_seq("ovrclr", 2, 10, 2, 0, 6, 6, 1'b0);
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    exp_err = 1'b0;
    chk("ovrclr_cleared", {31'd0, err_overrun}, 32'd0);

    // Reset while in PULSE
    cfg_pre_len = 16'd2; cfg_pulse_len = 16'd10; cfg_settle_len = 16'd2;
    sync_req = 1'b1;
    tick;
    sync_req = 1'b0;
    tick; tick; tick;
    chk("midrst_pre_mssi", {31'd0, mssi_sync}, 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("midrst_mssi", {31'd0, mssi_sync}, 32'd0);
    chk("midrst_ch", {28'd0, ch_enable}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_count", {24'd0, sync_count}, 32'd0);
    exp_cnt = 8'd0;
    exp_err = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick;
      chk("midrst_nodone", {31'd0, done}, 32'd0);
    end
    chk("midrst_count_after", {24'd0, sync_count}, 32'd0);

    // Config isolation, then wrap of the completed-sequence counter
    run_seq("iso", 1, 2, 3, 0, -1, -1, 1'b1);
    for (int i = 0; i < 255; i++) run_seq("wrap", 0, 0, 0, 0, -1, -1, 1'b0);
    chk("wrap_zero", {24'd0, sync_count}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
